pipe_hazard_sequencer: RTL and testbench
========================================

Name: pipe_hazard_sequencer

Overview:
- Central freeze/flush controller for the 5-stage core pipeline (IF, ID, EXE, MEM, WB).
- Combines three inputs: data-hazard stalls from the hazard unit, taken-branch flushes from EXE, and multi-cycle SRAM waits from MEM.
- Produces per-stage freeze, flush and bubble controls for the IF2ID, ID2EXE, EXE2MEM and MEM2WB registers.
- Holds a small FSM for memory waits with timeout, plus optional performance counters.

Parameters:
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before abort (1..255)
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
- hazard  in  1  data hazard detected in ID (combinational from hazard unit)
- branch_taken  in  1  EXE-stage branch resolved taken
- mem_req  in  1  MEM stage holds a load/store needing SRAM
- mem_ready  in  1  SRAM completes access this cycle
- freeze_if  out  1  hold PC and IF2ID
- freeze_id  out  1  hold ID2EXE
- freeze_exe  out  1  hold EXE2MEM
- freeze_mem  out  1  hold MEM2WB (insert no writeback)
- flush_if_id  out  1  load NOP into IF2ID
- flush_id_exe  out  1  load NOP into ID2EXE
- bubble_id  out  1  load NOP into ID2EXE, IF/IF2ID held (hazard stall)
- mem_err  out  1  sticky: SRAM wait timed out
- state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERR
- stall_cnt  out  CNT_W  cycles with any freeze asserted (optional feature)
- flush_cnt  out  CNT_W  branch flush events (optional feature)

Behaviour:
- Reset (rst=0 at edge): state=RUN, mem_err=0, timeout counter=0, counters=0. All control outputs are 0 during reset cycles.
- Control outputs are Mealy: combinational from registered state plus current inputs. Register updates happen at the clk edge.
- Priority: memory stall > branch flush > data hazard.
- RUN, mem_req=1, mem_ready=0:
  - assert all four freezes; flush/bubble = 0
  - next state MEM_WAIT; timeout counter <= 1
- RUN, mem_req=1, mem_ready=1: single-cycle access, no freeze, evaluate branch/hazard normally.
- RUN, no memory stall, branch_taken=1:
  - flush_if_id=1 and flush_id_exe=1 for exactly this cycle
  - hazard is ignored (the hazarded instruction is being flushed)
  - all freezes 0
- RUN, no memory stall, no branch, hazard=1:
  - freeze_if=1, bubble_id=1, flush_id_exe=0
  - EXE/MEM continue
- MEM_WAIT:
  - all four freezes = 1; flush_*=0 and bubble_id=0, even if branch_taken or hazard are high (both are re-evaluated after release, since EXE/ID are frozen and hold their values)
  - mem_ready=1: freezes still 1 this cycle; next state RUN; counter <= 0
  - otherwise counter increments. At counter==MEM_TIMEOUT without ready: mem_err <= 1, next state ERR
- ERR: all four freezes held 1 permanently. Only reset exits.
- Invariants:
  - flush_if_id and freeze_if are never both 1 (IF2ID ignores flush while frozen)
  - bubble_id and flush_id_exe are never both 1
- mem_req dropping in MEM_WAIT without mem_ready: treated as ready (return to RUN), no error.
- Reset mid-MEM_WAIT or in ERR: returns to RUN next cycle, mem_err cleared.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each cycle any freeze_* is 1
  - flush_cnt increments each cycle flush_if_id is 1
  - both saturate at all-ones and clear on reset
- Undefined: stall_cnt and flush_cnt tied to 0; no counter flops.

Test Plan:
- Reset: rst=0 for 2 cycles with hazard=1, branch_taken=1 -> all controls 0, state=0; release -> normal decode resumes.
- Hazard only: hazard=1 for 3 cycles -> freeze_if=1, bubble_id=1 for 3 cycles; freeze_id/exe/mem=0; stall_cnt=3.
- Branch+hazard same cycle: branch_taken=1, hazard=1 -> flush_if_id=1, flush_id_exe=1, freeze_if=0, bubble_id=0; flush_cnt=1.
- SRAM wait: mem_req=1, mem_ready rises on 4th cycle, branch_taken=1 throughout -> 4 cycles all freezes=1, no flush; 5th cycle state=RUN and flush pair asserted once.
- Timeout: mem_req=1, mem_ready=0 with MEM_TIMEOUT=15 -> mem_err=1 and state=2 after cycle 15, freezes stay 1; then rst=0 one cycle -> state=0, mem_err=0.
- Reset mid-wait: rst=0 in 2nd MEM_WAIT cycle -> next cycle state=0, freezes 0 (mem_req low), timeout counter restarts from 1 on next stall.

Source files
------------

// File: rtl/pipe_hazard_sequencer.sv
// Pipeline freeze/flush/bubble controller with a memory-wait FSM and timeout.
// Optional saturating stall/flush performance counters when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             freeze_if,
   output logic             freeze_id,
   output logic             freeze_exe,
   output logic             freeze_mem,
   output logic             flush_if_id,
   output logic             flush_id_exe,
   output logic             bubble_id,
   output logic             mem_err,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned TMO_W = 8;
   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             mem_err_q, mem_err_d;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_RUN;
         tmo_q     <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         mem_err_q <= mem_err_d;
      end
   end

   // Next state and Mealy controls; priority is memory stall, then branch, then hazard
   always_comb begin
      state_d      = state_q;
      tmo_d        = tmo_q;
      mem_err_d    = mem_err_q;
      freeze_if    = 1'b0;
      freeze_id    = 1'b0;
      freeze_exe   = 1'b0;
      freeze_mem   = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_exe = 1'b0;
      bubble_id    = 1'b0;
      if (rst) begin
         case (state_q)
            ST_RUN: begin
               if (mem_req && !mem_ready) begin
                  freeze_if  = 1'b1;
                  freeze_id  = 1'b1;
                  freeze_exe = 1'b1;
                  freeze_mem = 1'b1;
                  state_d    = ST_MEM_WAIT;
                  tmo_d      = TMO_W'(1);
               end else if (branch_taken) begin
                  flush_if_id  = 1'b1;
                  flush_id_exe = 1'b1;
               end else if (hazard) begin
                  freeze_if = 1'b1;
                  bubble_id = 1'b1;
               end
            end
            ST_MEM_WAIT: begin
               freeze_if  = 1'b1;
               freeze_id  = 1'b1;
               freeze_exe = 1'b1;
               freeze_mem = 1'b1;
               // A dropped request releases the pipeline just like a completed one
               if (mem_ready || !mem_req) begin
                  state_d = ST_RUN;
                  tmo_d   = '0;
               end else if (tmo_q == TMO_LIMIT) begin
                  state_d   = ST_ERR;
                  mem_err_d = 1'b1;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
               end
            end
            default: begin
               freeze_if  = 1'b1;
               freeze_id  = 1'b1;
               freeze_exe = 1'b1;
               freeze_mem = 1'b1;
            end
         endcase
      end
   end

   assign state   = state_q;
   assign mem_err = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic             any_freeze;

   assign any_freeze = freeze_if | freeze_id | freeze_exe | freeze_mem;

   // Saturating event counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (any_freeze && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_if_id && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Randomised bench for pipe_hazard_sequencer against a behavioural pipeline-control model.
module tb_pipe_hazard_sequencer;
   localparam int unsigned MEM_TIMEOUT = 15;
   localparam int unsigned CNT_W       = 32;
`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, hazard, branch_taken, mem_req, mem_ready;
   logic freeze_if, freeze_id, freeze_exe, freeze_mem;
   logic flush_if_id, flush_id_exe, bubble_id, mem_err;
   logic [1:0] state;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   pipe_hazard_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .freeze_if(freeze_if), .freeze_id(freeze_id), .freeze_exe(freeze_exe),
      .freeze_mem(freeze_mem), .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe),
      .bubble_id(bubble_id), .mem_err(mem_err), .state(state),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: mode 0 running, 1 waiting on SRAM, 2 aborted; waited = MEM_WAIT cycles entered
   int          m_mode   = 0;
   int          m_waited = 0;
   bit          m_err    = 1'b0;
   longint      m_stalls = 0;
   longint      m_flushes = 0;
   bit          primed   = 1'b0;
   logic [6:0]  last_ctl;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] sat(input longint v);
      return (v > longint'(32'hFFFF_FFFF)) ? 64'hFFFF_FFFF : 64'(v);
   endfunction

   // One clock cycle: drive, check Mealy outputs mid-cycle, advance model, step edge
   task automatic cyc(input bit r, input bit h, input bit b, input bit q, input bit y);
      bit   all_frz, fl, bub;
      logic [6:0] exp_ctl;
      rst = r; hazard = h; branch_taken = b; mem_req = q; mem_ready = y;
      #3;
      all_frz = 1'b0; fl = 1'b0; bub = 1'b0;
      if (r) begin
         if (m_mode != 0)      all_frz = 1'b1;
         else if (q && !y)     all_frz = 1'b1;
         else if (b)           fl = 1'b1;
         else if (h)           bub = 1'b1;
      end
      exp_ctl = {all_frz | bub, all_frz, all_frz, all_frz, fl, fl, bub};
      last_ctl = {freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if_id, flush_id_exe, bubble_id};
      chk("controls", 64'(last_ctl), 64'(exp_ctl));
      if (primed) begin
         chk("state", 64'(state), 64'(m_mode));
         chk("mem_err", 64'(mem_err), 64'(m_err));
         chk("stall_cnt", 64'(stall_cnt), PERF ? sat(m_stalls) : 64'd0);
         chk("flush_cnt", 64'(flush_cnt), PERF ? sat(m_flushes) : 64'd0);
      end
      if (!r) begin
         m_mode = 0; m_waited = 0; m_err = 1'b0; m_stalls = 0; m_flushes = 0;
      end else begin
         if (all_frz || bub) m_stalls++;
         if (fl)             m_flushes++;
         if (m_mode == 0 && q && !y) begin
            m_mode = 1; m_waited = 1;
         end else if (m_mode == 1) begin
            if (y || !q) begin
               m_mode = 0; m_waited = 0;
            end else if (m_waited >= int'(MEM_TIMEOUT)) begin
               m_mode = 2; m_err = 1'b1;
            end else begin
               m_waited++;
            end
         end
      end
      primed = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pq, py;
      rst = 1'b0; hazard = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
      #1;
      // Reset with hazard and branch high: controls forced low
      cyc(0, 1, 1, 0, 0);
      cyc(0, 1, 1, 0, 0);
      chk("lit_reset_state", 64'(state), 64'd0);
      // Hazard-only stall for three cycles
      repeat (3) cyc(1, 1, 0, 0, 0);
      chk("lit_hazard_ctl", 64'(last_ctl), 64'b1000001);
      chk("lit_hazard_stalls", 64'(stall_cnt), PERF ? 64'd3 : 64'd0);
      // Branch wins over hazard
      cyc(1, 1, 1, 0, 0);
      chk("lit_branch_ctl", 64'(last_ctl), 64'b0000110);
      chk("lit_branch_flushes", 64'(flush_cnt), PERF ? 64'd1 : 64'd0);
      // SRAM wait with branch held high; ready on the fourth cycle
      repeat (3) cyc(1, 0, 1, 1, 0);
      chk("lit_wait_ctl", 64'(last_ctl), 64'b1111000);
      cyc(1, 0, 1, 1, 1);
      chk("lit_wait_release", 64'(state), 64'd0);
      chk("lit_wait_stalls", 64'(stall_cnt), PERF ? 64'd7 : 64'd0);
      cyc(1, 0, 1, 0, 0);
      chk("lit_post_wait_ctl", 64'(last_ctl), 64'b0000110);
      // Timeout: abort after the fifteenth MEM_WAIT cycle
      cyc(1, 0, 0, 1, 0);
      repeat (14) cyc(1, 0, 0, 1, 0);
      chk("lit_tmo_pending", 64'(state), 64'd1);
      cyc(1, 0, 0, 1, 0);
      chk("lit_tmo_state", 64'(state), 64'd2);
      chk("lit_tmo_err", 64'(mem_err), 64'd1);
      repeat (3) cyc(1, $urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1));
      chk("lit_err_ctl", 64'(last_ctl), 64'b1111000);
      cyc(0, 0, 0, 0, 0);
      chk("lit_err_reset_state", 64'(state), 64'd0);
      chk("lit_err_reset_err", 64'(mem_err), 64'd0);
      // Reset during the second MEM_WAIT cycle, then a fresh full timeout
      cyc(1, 0, 0, 1, 0);
      cyc(1, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      chk("lit_midwait_reset", 64'(state), 64'd0);
      cyc(1, 1, 0, 0, 0);
      chk("lit_midwait_after", 64'(last_ctl), 64'b1000001);
      cyc(1, 0, 0, 1, 0);
      repeat (14) cyc(1, 0, 0, 1, 0);
      chk("lit_restart_pending", 64'(state), 64'd1);
      cyc(1, 0, 0, 1, 0);
      chk("lit_restart_err", 64'(state), 64'd2);
      // Randomised phases with varying SRAM behaviour
      for (int i = 0; i < 2500; i++) begin
         case (i / 500)
            0:       begin pq = 20; py = 50; end
            1:       begin pq = 60; py = 10; end
            2:       begin pq = 90; py = 2;  end
            3:       begin pq = 50; py = 30; end
            default: begin pq = 95; py = 0;  end
         endcase
         cyc($urandom_range(99) >= 2, $urandom_range(99) < 30, $urandom_range(99) < 20,
             $urandom_range(99) < pq, $urandom_range(99) < py);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
